// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA constants, command encodings, engine states and
//               a multiplier-free row-base helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int IDX_W  = 8;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    localparam logic OP_PIXEL = 1'b0;
    localparam logic OP_RECT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        FILL    = 2'd2
    } state_t;

    // y*H_RES as a constant shift-and-add tree; 640 reduces to (y<<9)+(y<<7)
    function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_RES[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_addr_walker.sv
`default_nettype none
// ============================================================================
// Module      : vga_addr_walker
// Description : Raster-order x/y walker producing row-major frame-buffer
//               addresses for an inclusive rectangle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_addr_walker
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [X_W-1:0]    i_x0,
    input  logic [X_W-1:0]    i_x1,
    input  logic [Y_W-1:0]    i_y0,
    input  logic [Y_W-1:0]    i_y1,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_last_nxt
);

    localparam logic [ADDR_W-1:0] c_h_step = ADDR_W'(H_RES);

    logic [X_W-1:0]    r_x, r_x0, r_x1;
    logic [Y_W-1:0]    r_y, r_y1;
    logic [ADDR_W-1:0] r_row_base, r_addr;

    logic              w_row_end;
    logic [X_W-1:0]    w_x_nxt, w_x1_nxt;
    logic [Y_W-1:0]    w_y_nxt, w_y1_nxt;
    logic [ADDR_W-1:0] w_base_load;

    always_comb begin
        w_row_end   = (r_x == r_x1);
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_x1_nxt    = r_x1;
        w_y1_nxt    = r_y1;
        w_base_load = row_base(i_y0);
        if (i_load) begin
            w_x_nxt  = i_x0;
            w_y_nxt  = i_y0;
            w_x1_nxt = i_x1;
            w_y1_nxt = i_y1;
        end else if (i_step) begin
            if (w_row_end) begin
                w_x_nxt = r_x0;
                w_y_nxt = r_y + Y_W'(1);
            end else begin
                w_x_nxt = r_x + X_W'(1);
            end
        end
        // Lookahead lets the top raise ready during the final write
        o_last_nxt = (w_x_nxt == w_x1_nxt) && (w_y_nxt == w_y1_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_x0       <= '0;
            r_x1       <= '0;
            r_y        <= '0;
            r_y1       <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_load) begin
            r_x        <= i_x0;
            r_x0       <= i_x0;
            r_x1       <= i_x1;
            r_y        <= i_y0;
            r_y1       <= i_y1;
            r_row_base <= w_base_load;
            r_addr     <= w_base_load + ADDR_W'(i_x0);
        end else if (i_step) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            if (w_row_end) begin
                r_row_base <= r_row_base + c_h_step;
                r_addr     <= r_row_base + c_h_step + ADDR_W'(r_x0);
            end else begin
                r_addr     <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_row_end && (r_y == r_y1);

endmodule
`default_nettype wire

// File: rtl/vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_filler
// Description : Pixel/rectangle fill engine feeding frame-buffer writes,
//               optionally deferred to the next vertical-sync falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_filler
    import vga_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic              iCMD_OP,
    input  logic              iCMD_WAIT_VS,
    input  logic [X_W-1:0]    iX0,
    input  logic [X_W-1:0]    iX1,
    input  logic [Y_W-1:0]    iY0,
    input  logic [Y_W-1:0]    iY1,
    input  logic [IDX_W-1:0]  iINDEX,
    input  logic              iVS,
    output logic              oWE,
    output logic [ADDR_W-1:0] oWADDR,
    output logic [IDX_W-1:0]  oWDATA,
    output logic              oBUSY,
    output logic              oERR,
    input  logic              iERR_CLR
);

    localparam logic [X_W-1:0] c_h_lim = X_W'(H_RES);
    localparam logic [Y_W-1:0] c_v_lim = Y_W'(V_RES);

    state_t             r_state, w_state_nxt;
    logic               r_cmd_ready, r_we, r_busy, r_err, r_vs;
    logic [IDX_W-1:0]   r_wdata;

    logic               w_accept, w_illegal, w_load, w_err_set;
    logic               w_vs_fall, w_step, w_last, w_last_nxt, w_ready_nxt;
    logic [X_W-1:0]     w_x1_eff;
    logic [Y_W-1:0]     w_y1_eff;

    // Pixel ops reuse the rectangle path as a 1x1 rectangle
    assign w_x1_eff  = (iCMD_OP == OP_RECT) ? iX1 : iX0;
    assign w_y1_eff  = (iCMD_OP == OP_RECT) ? iY1 : iY0;
    assign w_illegal = (iX0 > w_x1_eff) || (iY0 > w_y1_eff) ||
                       (w_x1_eff >= c_h_lim) || (w_y1_eff >= c_v_lim);
    assign w_accept  = iCMD_VALID && r_cmd_ready;
    assign w_load    = w_accept && !w_illegal;
    assign w_err_set = w_accept && w_illegal;
    assign w_vs_fall = r_vs && !iVS;
    assign w_step    = (r_state == FILL) && !w_last;

    vga_addr_walker u_walker (
        .clk        (iCLK),
        .rst        (iRST),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_x0       (iX0),
        .i_x1       (w_x1_eff),
        .i_y0       (iY0),
        .i_y1       (w_y1_eff),
        .o_addr     (oWADDR),
        .o_last     (w_last),
        .o_last_nxt (w_last_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = 1'b0;
        case (r_state)
            WAIT_VS: begin
                if (w_vs_fall) w_state_nxt = FILL;
            end
            FILL: begin
                if (w_last) begin
                    if (w_load) w_state_nxt = iCMD_WAIT_VS ? WAIT_VS : FILL;
                    else        w_state_nxt = IDLE;
                end
            end
            default: begin
                if (w_load) w_state_nxt = iCMD_WAIT_VS ? WAIT_VS : FILL;
            end
        endcase
        // Ready during the final write so a queued command follows gap-free
        case (w_state_nxt)
            IDLE:    w_ready_nxt = 1'b1;
            FILL:    w_ready_nxt = w_last_nxt;
            default: w_ready_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cmd_ready <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_vs        <= 1'b1;
            r_wdata     <= '0;
        end else begin
            r_cmd_ready <= w_ready_nxt;
            r_we        <= (w_state_nxt == FILL);
            r_busy      <= (w_state_nxt != IDLE);
            r_vs        <= iVS;
            if (w_load)        r_wdata <= iINDEX;
            if (w_err_set)     r_err   <= 1'b1;
            else if (iERR_CLR) r_err   <= 1'b0;
        end
    end

    assign oCMD_READY = r_cmd_ready;
    assign oWE        = r_we;
    assign oWDATA     = r_wdata;
    assign oBUSY      = r_busy;
    assign oERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rect_filler
// Description : Directed self-checking bench for vga_rect_filler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_filler;
    import vga_pkg::*;

    logic              iCLK = 1'b0;
    logic              iRST, iCMD_VALID, iCMD_OP, iCMD_WAIT_VS, iVS, iERR_CLR;
    logic [X_W-1:0]    iX0, iX1;
    logic [Y_W-1:0]    iY0, iY1;
    logic [IDX_W-1:0]  iINDEX;
    logic              oCMD_READY, oWE, oBUSY, oERR;
    logic [ADDR_W-1:0] oWADDR;
    logic [IDX_W-1:0]  oWDATA;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [IDX_W-1:0]  wr_data[$];
    int                wr_cyc[$];

    vga_rect_filler dut (
        .iCLK(iCLK), .iRST(iRST), .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY),
        .iCMD_OP(iCMD_OP), .iCMD_WAIT_VS(iCMD_WAIT_VS), .iX0(iX0), .iX1(iX1),
        .iY0(iY0), .iY1(iY1), .iINDEX(iINDEX), .iVS(iVS), .oWE(oWE),
        .oWADDR(oWADDR), .oWDATA(oWDATA), .oBUSY(oBUSY), .oERR(oERR),
        .iERR_CLR(iERR_CLR)
    );

    always #5 iCLK = ~iCLK;

    // Write log sampled mid-cycle, stamped with a running cycle number
    always @(negedge iCLK) begin
        cyc = cyc + 1;
        if (oWE === 1'b1) begin
            wr_addr.push_back(oWADDR);
            wr_data.push_back(oWDATA);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge iCLK);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic send_cmd(input logic op, input logic wvs, input int x0, input int x1,
                            input int y0, input int y1, input logic [7:0] idx);
        iCMD_OP = op; iCMD_WAIT_VS = wvs; iINDEX = idx;
        iX0 = X_W'(x0); iX1 = X_W'(x1); iY0 = Y_W'(y0); iY1 = Y_W'(y1);
        iCMD_VALID = 1'b1;
        @(posedge iCLK);
        #1;
        iCMD_VALID = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        n_vec++; if (oCMD_READY !== 1'b0) begin n_miss++; $display("FAIL rst_ready: got %b want 0", oCMD_READY); end
        n_vec++; if (oWE !== 1'b0) begin n_miss++; $display("FAIL rst_we: got %b want 0", oWE); end
        n_vec++; if (oWADDR !== '0 || oWDATA !== '0) begin n_miss++; $display("FAIL rst_addr_data: got %0d/%h want 0/00", oWADDR, oWDATA); end
        n_vec++; if (oBUSY !== 1'b0 || oERR !== 1'b0) begin n_miss++; $display("FAIL rst_busy_err: got %b/%b want 0/0", oBUSY, oERR); end
        iRST = 1'b0;
        tick(1);
        n_vec++; if (oCMD_READY !== 1'b1) begin n_miss++; $display("FAIL rst_release_ready: got %b want 1", oCMD_READY); end
    endtask

    task automatic test_pixel();
        int c0;
        clear_log();
        c0 = cyc;
        // iX1/iY1 left at 0: a pixel op must ignore them
        send_cmd(OP_PIXEL, 1'b0, 5, 0, 2, 0, 8'h3C);
        tick(1);
        n_vec++; if (oWE !== 1'b1) begin n_miss++; $display("FAIL pix_we_t1: got %b want 1", oWE); end
        tick(1);
        n_vec++; if (oCMD_READY !== 1'b1 || oBUSY !== 1'b0) begin n_miss++; $display("FAIL pix_ready_t2: ready/busy got %b/%b want 1/0", oCMD_READY, oBUSY); end
        tick(3);
        n_vec++; if (wr_addr.size() != 1) begin n_miss++; $display("FAIL pix_count: got %0d writes want 1", wr_addr.size()); end
        else begin
            n_vec++; if (wr_addr[0] !== 19'd1285 || wr_data[0] !== 8'h3C) begin n_miss++; $display("FAIL pix_write: got %0d/%h want 1285/3c", wr_addr[0], wr_data[0]); end
            n_vec++; if (wr_cyc[0] != c0 + 1) begin n_miss++; $display("FAIL pix_latency: got cycle %0d want %0d", wr_cyc[0], c0 + 1); end
        end
    endtask

    task automatic test_rect();
        logic [ADDR_W-1:0] exp_a[4];
        exp_a = '{19'd306558, 19'd306559, 19'd307198, 19'd307199};
        clear_log();
        send_cmd(OP_RECT, 1'b0, 638, 639, 478, 479, 8'hFF);
        tick(8);
        n_vec++; if (wr_addr.size() != 4) begin n_miss++; $display("FAIL rect_count: got %0d want 4", wr_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 8'hFF) begin n_miss++; $display("FAIL rect_write%0d: got %0d/%h want %0d/ff", i, wr_addr[i], wr_data[i], exp_a[i]); end
            end
            n_vec++; if (wr_cyc[3] != wr_cyc[0] + 3) begin n_miss++; $display("FAIL rect_contig: span got %0d want 3", wr_cyc[3] - wr_cyc[0]); end
        end
        n_vec++; if (oERR !== 1'b0) begin n_miss++; $display("FAIL rect_err: got %b want 0", oERR); end
    endtask

    task automatic test_illegal();
        clear_log();
        send_cmd(OP_RECT, 1'b0, 10, 9, 0, 0, 8'h01);
        tick(4);
        n_vec++; if (wr_addr.size() != 0 || oERR !== 1'b1) begin n_miss++; $display("FAIL ill_x_order: writes/err got %0d/%b want 0/1", wr_addr.size(), oERR); end
        n_vec++; if (oCMD_READY !== 1'b1 || oBUSY !== 1'b0) begin n_miss++; $display("FAIL ill_idle: ready/busy got %b/%b want 1/0", oCMD_READY, oBUSY); end
        send_cmd(OP_RECT, 1'b0, 0, 640, 0, 0, 8'h02);
        tick(4);
        n_vec++; if (wr_addr.size() != 0 || oERR !== 1'b1) begin n_miss++; $display("FAIL ill_x_range: writes/err got %0d/%b want 0/1", wr_addr.size(), oERR); end
        iERR_CLR = 1'b1;
        tick(1);
        iERR_CLR = 1'b0;
        n_vec++; if (oERR !== 1'b0) begin n_miss++; $display("FAIL ill_clear: got %b want 0", oERR); end
        iERR_CLR = 1'b1;
        send_cmd(OP_RECT, 1'b0, 0, 0, 0, 480, 8'h03);
        iERR_CLR = 1'b0;
        n_vec++; if (oERR !== 1'b1) begin n_miss++; $display("FAIL ill_set_wins: got %b want 1", oERR); end
        tick(3);
        n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL ill_y_range_writes: got %0d want 0", wr_addr.size()); end
        iERR_CLR = 1'b1;
        tick(1);
        iERR_CLR = 1'b0;
    endtask

    task automatic test_vsync_wait();
        int c0;
        clear_log();
        iVS = 1'b0;
        tick(1);
        send_cmd(OP_PIXEL, 1'b1, 1, 0, 1, 0, 8'h11);
        tick(5);
        n_vec++; if (wr_addr.size() != 0 || oBUSY !== 1'b1 || oCMD_READY !== 1'b0) begin n_miss++; $display("FAIL vs_hold_low: writes/busy/ready got %0d/%b/%b want 0/1/0", wr_addr.size(), oBUSY, oCMD_READY); end
        iVS = 1'b1;
        tick(3);
        n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL vs_hold_high: got %0d writes want 0", wr_addr.size()); end
        iVS = 1'b0;
        c0 = cyc;
        tick(3);
        n_vec++; if (wr_addr.size() != 1) begin n_miss++; $display("FAIL vs_count: got %0d want 1", wr_addr.size()); end
        else begin
            n_vec++; if (wr_addr[0] !== 19'd641 || wr_data[0] !== 8'h11) begin n_miss++; $display("FAIL vs_write: got %0d/%h want 641/11", wr_addr[0], wr_data[0]); end
            n_vec++; if (wr_cyc[0] != c0 + 1) begin n_miss++; $display("FAIL vs_latency: got cycle %0d want %0d", wr_cyc[0], c0 + 1); end
        end
        iVS = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid_fill();
        int k;
        clear_log();
        send_cmd(OP_RECT, 1'b0, 0, 9, 0, 9, 8'h5A);
        k = 0;
        while (wr_addr.size() < 37 && k < 60) begin
            tick(1);
            k++;
        end
        n_vec++; if (wr_addr.size() < 37) begin n_miss++; $display("FAIL mid_timeout: got %0d writes want 37", wr_addr.size()); end
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        #1;
        n_vec++; if (oWE !== 1'b0 || oBUSY !== 1'b0 || oCMD_READY !== 1'b0) begin n_miss++; $display("FAIL mid_abort: we/busy/ready got %b/%b/%b want 0/0/0", oWE, oBUSY, oCMD_READY); end
        n_vec++; if (wr_addr.size() != 37 || wr_addr[36] !== 19'd1926) begin n_miss++; $display("FAIL mid_37th: count %0d last %0d want 37/1926", wr_addr.size(), wr_addr[wr_addr.size()-1]); end
        tick(2);
        iRST = 1'b0;
        clear_log();
        #1;
        n_vec++; if (oCMD_READY !== 1'b0) begin n_miss++; $display("FAIL mid_ready_early: got %b want 0", oCMD_READY); end
        tick(1);
        n_vec++; if (oCMD_READY !== 1'b1 || oWE !== 1'b0 || oWADDR !== '0 || oWDATA !== '0) begin n_miss++; $display("FAIL mid_post_rst: ready/we/addr/data got %b/%b/%0d/%h want 1/0/0/00", oCMD_READY, oWE, oWADDR, oWDATA); end
        tick(3);
        n_vec++; if (wr_addr.size() != 0) begin n_miss++; $display("FAIL mid_no_resume: got %0d writes want 0", wr_addr.size()); end
        send_cmd(OP_PIXEL, 1'b0, 9, 0, 9, 0, 8'h77);
        tick(3);
        n_vec++; if (wr_addr.size() != 1 || wr_addr[0] !== 19'd5769 || wr_data[0] !== 8'h77) begin n_miss++; $display("FAIL mid_new_pixel: count %0d want 1 at 5769/77", wr_addr.size()); end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] exp_a[7];
        logic [IDX_W-1:0]  exp_d[7];
        int k;
        exp_a = '{19'd6500, 19'd6501, 19'd6502, 19'd3200, 19'd3201, 19'd3840, 19'd3841};
        exp_d = '{8'hA1, 8'hA1, 8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2};
        clear_log();
        iCMD_OP = OP_RECT; iCMD_WAIT_VS = 1'b0; iINDEX = 8'hA1;
        iX0 = 10'd100; iX1 = 10'd102; iY0 = 9'd10; iY1 = 9'd10;
        iCMD_VALID = 1'b1;
        @(posedge iCLK);
        #1;
        iINDEX = 8'hB2; iX0 = 10'd0; iX1 = 10'd1; iY0 = 9'd5; iY1 = 9'd6;
        n_vec++; if (oCMD_READY !== 1'b0) begin n_miss++; $display("FAIL b2b_ready_first: got %b want 0", oCMD_READY); end
        k = 0;
        while (oCMD_READY !== 1'b1 && k < 10) begin
            @(posedge iCLK);
            #1;
            k++;
        end
        n_vec++; if (oCMD_READY !== 1'b1) begin n_miss++; $display("FAIL b2b_timeout: ready got %b want 1", oCMD_READY); end
        @(posedge iCLK);
        #1;
        iCMD_VALID = 1'b0;
        tick(8);
        n_vec++; if (wr_addr.size() != 7) begin n_miss++; $display("FAIL b2b_count: got %0d want 7", wr_addr.size()); end
        else begin
            for (int i = 0; i < 7; i++) begin
                n_vec++; if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i] || wr_cyc[i] != wr_cyc[0] + i) begin n_miss++; $display("FAIL b2b_write%0d: got %0d/%h cyc+%0d want %0d/%h cyc+%0d", i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], exp_a[i], exp_d[i], i); end
            end
        end
    endtask

    initial begin
        iRST = 1'b1; iCMD_VALID = 1'b0; iCMD_OP = 1'b0; iCMD_WAIT_VS = 1'b0;
        iX0 = '0; iX1 = '0; iY0 = '0; iY1 = '0; iINDEX = '0;
        iVS = 1'b1; iERR_CLR = 1'b0;
        test_reset();
        test_pixel();
        test_rect();
        test_illegal();
        test_vsync_wait();
        test_reset_mid_fill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
